// File: rtl/rggen_native_buffered_adapter.sv
// ---------------------------------------------------------------------------
// rggen_native_buffered_adapter
//
// Native CSR-bus slave adapter with split request/response channels. Incoming
// requests are queued in a small FIFO and issued one at a time to the register
// array. Exactly one response is returned per request, in request order. An
// optional address pre-decode and an optional access timeout are provided.
//
// Ports
//   i_clk / i_rst_n            clock, asynchronous active-low reset
//   i_csrbus_*                 request channel (valid, access, address, data, strobe)
//   o_csrbus_request_ready     request FIFO not full
//   o_csrbus_response_valid    response channel valid; i_csrbus_response_ready accepts
//   o_csrbus_status/read_data  response payload, held until accepted
//   o_register_*               command to the register array (held while valid)
//   i_register_*               per-register active/ready/status/read data
//   o_timeout                  one-cycle pulse when an access times out
// ---------------------------------------------------------------------------
module rggen_native_buffered_adapter #(
    parameter int                    ADDRESS_WIDTH       = 8,
    parameter int                    LOCAL_ADDRESS_WIDTH = 8,
    parameter int                    BUS_WIDTH           = 32,
    parameter int                    STROBE_WIDTH        = BUS_WIDTH / 8,
    parameter int                    REGISTERS           = 1,
    parameter int                    REQUEST_DEPTH       = 2,
    parameter bit                    PRE_DECODE          = 1'b0,
    parameter logic [63:0]           BASE_ADDRESS        = 64'd0,
    parameter logic [63:0]           BYTE_SIZE           = 64'd256,
    parameter bit                    ERROR_STATUS        = 1'b0,
    parameter logic [BUS_WIDTH-1:0]  DEFAULT_READ_DATA   = '0,
    parameter int                    TIMEOUT_CYCLES      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_csrbus_valid,
    output logic                           o_csrbus_request_ready,
    input  logic [1:0]                     i_csrbus_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_csrbus_address,
    input  logic [BUS_WIDTH-1:0]           i_csrbus_write_data,
    input  logic [STROBE_WIDTH-1:0]        i_csrbus_strobe,
    output logic                           o_csrbus_response_valid,
    input  logic                           i_csrbus_response_ready,
    output logic [1:0]                     o_csrbus_status,
    output logic [BUS_WIDTH-1:0]           o_csrbus_read_data,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data,
    output logic                           o_timeout
);

    // Pointers carry one extra bit so full and empty can be told apart;
    // 2*REQUEST_DEPTH is a power of two, so they wrap naturally.
    localparam int PW = $clog2(REQUEST_DEPTH) + 1;
    localparam int IW = (REQUEST_DEPTH > 1) ? $clog2(REQUEST_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] CNT_LAST    = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0]    MISS_STATUS = ERROR_STATUS ? 2'b11 : 2'b00;

    typedef struct packed {
        logic [1:0]               access;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [BUS_WIDTH-1:0]     write_data;
        logic [STROBE_WIDTH-1:0]  strobe;
    } request_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESPOND
    } state_t;

    function automatic logic [IW-1:0] slot(input logic [PW-1:0] ptr);
        if (REQUEST_DEPTH == 1) return '0;
        else                    return ptr[IW-1:0];
    endfunction

    // ---------------- request FIFO ----------------
    request_t        fifo_mem [REQUEST_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   fill;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    request_t        req_in;
    request_t        head;

    assign fill  = wr_ptr - rd_ptr;
    assign full  = (fill == PW'(REQUEST_DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    // No same-cycle pop bypass: a full FIFO refuses even if the head leaves.
    assign push  = i_csrbus_valid && !full;
    assign o_csrbus_request_ready = !full;

    assign req_in = '{access: i_csrbus_access, address: i_csrbus_address,
                      write_data: i_csrbus_write_data, strobe: i_csrbus_strobe};
    assign head   = fifo_mem[slot(rd_ptr)];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < REQUEST_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[slot(wr_ptr)] <= req_in;
                wr_ptr                 <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // ---------------- address pre-decode ----------------
    logic [63:0] head_address;
    logic        head_in_range;

    assign head_address  = 64'(head.address);
    assign head_in_range = (head_address >= BASE_ADDRESS) &&
                           (head_address <  BASE_ADDRESS + BYTE_SIZE);

    // ---------------- register response mux ----------------
    logic [REGISTERS-1:0] hit;
    logic [1:0]           mux_status;
    logic [BUS_WIDTH-1:0] mux_data;

    assign hit = i_register_ready & i_register_active;

    always_comb begin
        mux_status = '0;
        mux_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (hit[i]) begin
                mux_status = mux_status | i_register_status[2*i +: 2];
                mux_data   = mux_data   | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    // ---------------- FSM ----------------
    state_t                   state_q;
    state_t                   state_d;
    logic [TW-1:0]            cnt_q;
    logic [1:0]               cmd_access;
    logic [LOCAL_ADDRESS_WIDTH-1:0] cmd_address;
    logic [BUS_WIDTH-1:0]     cmd_write_data;
    logic [STROBE_WIDTH-1:0]  cmd_strobe;
    logic [1:0]               status_q;
    logic [1:0]               status_d;
    logic [BUS_WIDTH-1:0]     data_q;
    logic [BUS_WIDTH-1:0]     data_d;
    logic                     timeout_q;
    logic                     timeout_d;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        status_d  = status_q;
        data_d    = data_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (PRE_DECODE && !head_in_range) begin
                        state_d  = RESPOND;
                        status_d = MISS_STATUS;
                        data_d   = DEFAULT_READ_DATA;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (|hit) begin
                    state_d  = RESPOND;
                    status_d = mux_status;
                    data_d   = mux_data;
                end else if (i_register_active == '0) begin
                    state_d  = RESPOND;
                    status_d = MISS_STATUS;
                    data_d   = DEFAULT_READ_DATA;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = RESPOND;
                    status_d  = 2'b10;
                    data_d    = DEFAULT_READ_DATA;
                    timeout_d = 1'b1;
                end
            end
            RESPOND: begin
                if (i_csrbus_response_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cmd_access     <= '0;
            cmd_address    <= '0;
            cmd_write_data <= '0;
            cmd_strobe     <= '0;
            status_q       <= '0;
            data_q         <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            // Counter restarts every time a command enters ISSUE.
            cnt_q     <= (state_q == ISSUE) ? cnt_q + TW'(1) : '0;
            if (pop) begin
                cmd_access     <= head.access;
                cmd_address    <= head.address[LOCAL_ADDRESS_WIDTH-1:0];
                cmd_write_data <= head.write_data;
                cmd_strobe     <= head.strobe;
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_register_valid        = (state_q == ISSUE);
    assign o_register_access       = cmd_access;
    assign o_register_address      = cmd_address;
    assign o_register_write_data   = cmd_write_data;
    assign o_csrbus_response_valid = (state_q == RESPOND);
    assign o_csrbus_status         = status_q;
    assign o_csrbus_read_data      = data_q;
    assign o_timeout               = timeout_q;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_strobe
        assign o_register_strobe[i] = cmd_strobe[i/8];
    end

endmodule

// File: tb/tb_rggen_native_buffered_adapter.sv
// Randomized bench for rggen_native_buffered_adapter with an in-bench
// transaction-level model (request queue + one outstanding command).
module tb_rggen_native_buffered_adapter;

    localparam logic [31:0] DEF_DATA = 32'hBAADF00D;
    localparam int          DEPTH    = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_csrbus_valid = 1'b0;
    logic        o_csrbus_request_ready;
    logic [1:0]  i_csrbus_access = '0;
    logic [11:0] i_csrbus_address = '0;
    logic [31:0] i_csrbus_write_data = '0;
    logic [3:0]  i_csrbus_strobe = '0;
    logic        o_csrbus_response_valid;
    logic        i_csrbus_response_ready = 1'b0;
    logic [1:0]  o_csrbus_status;
    logic [31:0] o_csrbus_read_data;
    logic        o_register_valid;
    logic [1:0]  o_register_access;
    logic [7:0]  o_register_address;
    logic [31:0] o_register_write_data;
    logic [31:0] o_register_strobe;
    logic [1:0]  i_register_active = '0;
    logic [1:0]  i_register_ready = '0;
    logic [3:0]  i_register_status = '0;
    logic [63:0] i_register_read_data = '0;
    logic        o_timeout;

    rggen_native_buffered_adapter #(
        .ADDRESS_WIDTH(12), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
        .REQUEST_DEPTH(DEPTH), .PRE_DECODE(1'b1), .BASE_ADDRESS(64'h100),
        .BYTE_SIZE(64'h100), .ERROR_STATUS(1'b1), .DEFAULT_READ_DATA(DEF_DATA),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_csrbus_valid(i_csrbus_valid), .o_csrbus_request_ready(o_csrbus_request_ready),
        .i_csrbus_access(i_csrbus_access), .i_csrbus_address(i_csrbus_address),
        .i_csrbus_write_data(i_csrbus_write_data), .i_csrbus_strobe(i_csrbus_strobe),
        .o_csrbus_response_valid(o_csrbus_response_valid),
        .i_csrbus_response_ready(i_csrbus_response_ready),
        .o_csrbus_status(o_csrbus_status), .o_csrbus_read_data(o_csrbus_read_data),
        .o_register_valid(o_register_valid), .o_register_access(o_register_access),
        .o_register_address(o_register_address), .o_register_write_data(o_register_write_data),
        .o_register_strobe(o_register_strobe), .i_register_active(i_register_active),
        .i_register_ready(i_register_ready), .i_register_status(i_register_status),
        .i_register_read_data(i_register_read_data), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // kind: 0 = register answers after d wait cycles on lanes 'mask',
    //       1 = no register active (decode miss), 2 = never ready (timeout)
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  d;
        logic [1:0]  mask;
        logic [3:0]  st;
        logic [63:0] dat;
    } plan_t;

    typedef struct packed {
        logic [1:0]  acc;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        plan_t       p;
    } txn_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [11:0] a);
        return (a >= 12'h100) && (a < 12'h200);
    endfunction

    function automatic int plan_len(input txn_t t);
        if (!in_rng(t.addr)) return 0;
        case (t.p.kind)
            2'd0:    return int'(t.p.d) + 1;
            2'd1:    return 1;
            default: return 8;
        endcase
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        int r = $urandom_range(0, 9);
        p.kind = (r < 6) ? 2'd0 : ((r < 8) ? 2'd1 : 2'd2);
        p.d    = 4'($urandom_range(0, 7));
        p.mask = 2'($urandom_range(1, 3));
        p.st   = 4'($urandom);
        p.dat  = {$urandom, $urandom};
        return p;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] s);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) e[8*i +: 8] = {8{s[i]}};
        return e;
    endfunction

    // ---------------- behavioural model ----------------
    txn_t        q[$];
    txn_t        cur;
    bit          busy = 0;
    int          rem = 0;
    int          cur_len = 0;
    logic [1:0]  exp_st = '0;
    logic [31:0] exp_dat = '0;
    bit          exp_to = 0;
    plan_t       drv_plan = '0;
    int          rsp_mode = 1;   // 0: hold off, 1: always accept, 2: random

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q.delete();
            busy   = 0;
            rem    = 0;
            exp_to = 0;
        end else begin
            bit   was_busy;
            int   n0;
            txn_t t;
            was_busy = busy;
            n0       = q.size();
            exp_to   = 0;
            if (busy) begin
                if (rem > 0) begin
                    rem--;
                    if (rem == 0 && cur.p.kind == 2'd2 && in_rng(cur.addr)) exp_to = 1;
                end else if (i_csrbus_response_ready) begin
                    busy = 0;
                end
            end
            if (!was_busy && n0 > 0) begin
                cur     = q.pop_front();
                busy    = 1;
                cur_len = plan_len(cur);
                rem     = cur_len;
                if (!in_rng(cur.addr) || cur.p.kind == 2'd1) begin
                    exp_st = 2'b11; exp_dat = DEF_DATA;
                end else if (cur.p.kind == 2'd0) begin
                    exp_st  = (cur.p.mask[0] ? cur.p.st[1:0] : 2'b00) | (cur.p.mask[1] ? cur.p.st[3:2] : 2'b00);
                    exp_dat = (cur.p.mask[0] ? cur.p.dat[31:0] : 32'h0) | (cur.p.mask[1] ? cur.p.dat[63:32] : 32'h0);
                end else begin
                    exp_st = 2'b10; exp_dat = DEF_DATA;
                end
            end
            if (i_csrbus_valid && n0 < DEPTH) begin
                t.acc = i_csrbus_access; t.addr = i_csrbus_address;
                t.wd  = i_csrbus_write_data; t.strb = i_csrbus_strobe; t.p = drv_plan;
                q.push_back(t);
            end
        end
    end

    // ---------------- compare + register-side responder ----------------
    always @(negedge i_clk) begin
        bit exp_rv, exp_pv;
        exp_rv = busy && rem > 0;
        exp_pv = busy && rem == 0;
        chk("request_ready", o_csrbus_request_ready, q.size() < DEPTH);
        chk("register_valid", o_register_valid, exp_rv);
        chk("response_valid", o_csrbus_response_valid, exp_pv);
        chk("timeout", o_timeout, exp_to);
        if (exp_rv && o_register_valid) begin
            chk("reg_access", o_register_access, cur.acc);
            chk("reg_address", o_register_address, cur.addr[7:0]);
            chk("reg_wdata", o_register_write_data, cur.wd);
            chk("reg_strobe", o_register_strobe, expand(cur.strb));
        end
        if (exp_pv && o_csrbus_response_valid) begin
            chk("rsp_status", o_csrbus_status, exp_st);
            chk("rsp_data", o_csrbus_read_data, exp_dat);
        end
        // drive the register array for the coming cycle
        i_register_status    = 4'($urandom);
        i_register_read_data = {$urandom, $urandom};
        if (exp_rv) begin
            int          idx;
            logic [1:0]  r;
            idx = cur_len - rem;
            r   = 2'($urandom);
            i_register_status    = cur.p.st;
            i_register_read_data = cur.p.dat;
            case (cur.p.kind)
                2'd0: begin
                    i_register_active = cur.p.mask;
                    i_register_ready  = (idx == int'(cur.p.d)) ? (cur.p.mask | (r & ~cur.p.mask)) : (r & ~cur.p.mask);
                end
                2'd1: begin
                    i_register_active = 2'b00;
                    i_register_ready  = r;
                end
                default: begin
                    i_register_active = cur.p.mask;
                    i_register_ready  = r & ~cur.p.mask;
                end
            endcase
        end else begin
            i_register_active = 2'($urandom);
            i_register_ready  = 2'($urandom);
        end
        case (rsp_mode)
            0:       i_csrbus_response_ready = 1'b0;
            1:       i_csrbus_response_ready = 1'b1;
            default: i_csrbus_response_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- stimulus ----------------
    function automatic plan_t mk_plan(input logic [1:0] kind, input logic [3:0] d,
                                      input logic [1:0] mask, input logic [3:0] st,
                                      input logic [63:0] dat);
        plan_t p;
        p.kind = kind; p.d = d; p.mask = mask; p.st = st; p.dat = dat;
        return p;
    endfunction

    task automatic push_one(input logic [1:0] acc, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] strb, input plan_t p);
        int n = 0;
        @(negedge i_clk);
        i_csrbus_valid = 1'b1; i_csrbus_access = acc; i_csrbus_address = addr;
        i_csrbus_write_data = wd; i_csrbus_strobe = strb; drv_plan = p;
        while (!o_csrbus_request_ready && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 40) begin
            miscompares++;
            $display("FAIL push_accept: request_ready stayed 0 for %0d cycles", n);
        end
        @(posedge i_clk);
        #1 i_csrbus_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL wait_idle: model still busy after %0d cycles", n);
        end
        @(negedge i_clk);
    endtask

    initial begin
        int          nv, nt, seen;
        logic [1:0]  ts;
        logic [31:0] td;

        // reset state
        repeat (3) @(negedge i_clk);
        chk("reset_request_ready", o_csrbus_request_ready, 1'b1);
        chk("reset_response_valid", o_csrbus_response_valid, 1'b0);
        chk("reset_register_valid", o_register_valid, 1'b0);
        chk("reset_status_data", {o_csrbus_status, o_csrbus_read_data}, 34'h0);
        #2 i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // 1: read hits lane 1 immediately
        push_one(2'b00, 12'h104, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b10, 4'b0000, {32'hDEADBEEF, 32'h11111111}));
        @(negedge i_clk);
        @(negedge i_clk);
        chk("t1_register_valid", o_register_valid, 1'b1);
        chk("t1_response_early", o_csrbus_response_valid, 1'b0);
        @(negedge i_clk);
        chk("t1_response_valid", o_csrbus_response_valid, 1'b1);
        chk("t1_status", o_csrbus_status, 2'b00);
        chk("t1_data", o_csrbus_read_data, 32'hDEADBEEF);
        wait_idle();

        // 5: write with strobe 0101
        push_one(2'b01, 12'h1A5, 32'h12345678, 4'b0101, mk_plan(2'd0, 4'd1, 2'b01, 4'b0000, 64'h0));
        @(negedge i_clk);
        @(negedge i_clk);
        chk("t5_strobe", o_register_strobe, 32'h00FF00FF);
        chk("t5_wdata", o_register_write_data, 32'h12345678);
        chk("t5_address", o_register_address, 8'hA5);
        wait_idle();

        // 3: timeout after 8 ISSUE cycles
        nv = 0; nt = 0; ts = '0; td = '0;
        push_one(2'b00, 12'h110, 32'h0, 4'hF, mk_plan(2'd2, 4'd0, 2'b11, 4'b0101, 64'h5555_5555_6666_6666));
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_register_valid) nv++;
            if (o_timeout) begin nt++; ts = o_csrbus_status; td = o_csrbus_read_data; end
        end
        chk("t3_valid_cycles", 64'(nv), 64'd8);
        chk("t3_timeout_pulses", 64'(nt), 64'd1);
        chk("t3_status", ts, 2'b10);
        chk("t3_data", td, DEF_DATA);
        wait_idle();

        // 4: pre-decode miss, never reaches the register array
        nv = 0; seen = 0;
        push_one(2'b00, 12'h080, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b01, 4'b0000, 64'h0));
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_register_valid) nv++;
            if (o_csrbus_response_valid && seen == 0) begin
                seen = 1; ts = o_csrbus_status; td = o_csrbus_read_data;
            end
        end
        chk("t4_register_valid", 64'(nv), 64'd0);
        chk("t4_response_seen", 64'(seen), 64'd1);
        chk("t4_status", ts, 2'b11);
        chk("t4_data", td, DEF_DATA);
        wait_idle();

        // 2: back-pressure with a stalled response
        rsp_mode = 0;
        @(negedge i_clk);
        push_one(2'b00, 12'h120, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b01, 4'b0001, 64'hA1));
        push_one(2'b00, 12'h124, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b01, 4'b0010, 64'hB2));
        push_one(2'b00, 12'h128, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b10, 4'b0000, 64'hC3_0000_0000));
        @(negedge i_clk);
        chk("t2_request_ready_full", o_csrbus_request_ready, 1'b0);
        rsp_mode = 1;
        push_one(2'b00, 12'h12C, 32'h0, 4'hF, mk_plan(2'd1, 4'd0, 2'b01, 4'b0000, 64'h0));
        wait_idle();

        // 6: reset while a command is in ISSUE with two queued
        push_one(2'b00, 12'h130, 32'h0, 4'hF, mk_plan(2'd2, 4'd0, 2'b01, 4'b0000, 64'h0));
        push_one(2'b00, 12'h134, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b01, 4'b0000, 64'h0));
        push_one(2'b00, 12'h138, 32'h0, 4'hF, mk_plan(2'd0, 4'd0, 2'b01, 4'b0000, 64'h0));
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t6_register_valid", o_register_valid, 1'b0);
        chk("t6_response_valid", o_csrbus_response_valid, 1'b0);
        chk("t6_request_ready", o_csrbus_request_ready, 1'b1);
        chk("t6_outputs_zero", {o_csrbus_status, o_csrbus_read_data, o_register_strobe, o_timeout}, 67'h0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_csrbus_response_valid || o_register_valid) nv++;
        end
        chk("t6_no_stale_activity", 64'(nv), 64'd0);

        // random traffic
        rsp_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge i_clk);
            i_csrbus_valid      = ($urandom_range(0, 2) != 0);
            i_csrbus_access     = 2'($urandom);
            i_csrbus_address    = ($urandom_range(0, 9) < 7) ? 12'(12'h100 + $urandom_range(0, 255))
                                                             : 12'($urandom);
            i_csrbus_write_data = $urandom;
            i_csrbus_strobe     = 4'($urandom);
            drv_plan            = rand_plan();
        end
        @(negedge i_clk);
        i_csrbus_valid = 1'b0;
        rsp_mode = 1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
